// File: rtl/line_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_responder_if
//  Description : 128-bit cache line memory bus between a cache memory port
//                (master) and the line memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         busy;
    logic         err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_responder
//  Description : Slow line memory model; services held read/write requests
//                after LAT cycles with a single-cycle mem_ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
    parameter int LAT    = 4,
    parameter int ADDR_W = 8
) (
    input  wire logic            clk,
    input  wire logic            proc_reset,
    line_mem_responder_if.slave  bus
);
    localparam int          DEPTH      = 2 ** ADDR_W;
    localparam logic [3:0]  C_CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_COOL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [127:0]        wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [127:0]        rdata_q, rdata_d;
    logic                err_q, err_d;

    // Line storage carries no reset; contents are undefined until written.
    logic [127:0]        lines_q [DEPTH];

    logic [ADDR_W-1:0]   w_req_idx;
    logic                w_req;
    logic                w_mem_we;
    logic                w_unused_addr;

    assign w_req_idx     = bus.mem_addr[ADDR_W-1:0];
    assign w_req         = bus.mem_read | bus.mem_write;
    assign w_unused_addr = ^bus.mem_addr[27:ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    idx_d   = w_req_idx;
                    wdata_d = bus.mem_wdata;
                    wr_d    = bus.mem_write;
                    if (bus.mem_read && bus.mem_write) begin
                        err_d = 1'b1;
                    end
                    // A single-cycle latency skips WAIT, so the read uses the live address.
                    if (LAT == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                        if (!bus.mem_write) begin
                            rdata_d = lines_q[w_req_idx];
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = C_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    if (!wr_q) begin
                        rdata_d = lines_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_COOL;
            ST_COOL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Commit on the edge leaving RESP; a reset forces IDLE first and drops the write.
    assign w_mem_we = (state_q == ST_RESP) && wr_q;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            lines_q[idx_q] <= wdata_q;
        end
    end

    assign bus.mem_ready = (state_q == ST_RESP);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.err       = err_q;
    assign bus.mem_rdata = rdata_q;

endmodule
`default_nettype wire
